// File: rtl/imem_responder_pkg.sv
// Shared constants and FSM state type for the instruction-memory responder.
package imem_responder_pkg;

  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam logic [63:0] IMEM_BASE = 64'h0000_0000_8000_0000;
  localparam int unsigned CntWidth  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } imem_state_e;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-port bundle between the core (master) and the instruction memory (slave).
interface imem_responder_if;

  logic        inst_ena;
  logic [63:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_err;

  modport master (
    output inst_ena, inst_addr,
    input  inst_ready, inst, inst_valid, inst_err
  );

  modport slave (
    input  inst_ena, inst_addr,
    output inst_ready, inst, inst_valid, inst_err
  );

endinterface

// File: rtl/imem_array.sv
// 1-write/1-read synchronous word array; a same-edge read returns the pre-write data.
module imem_array #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // Contents are deliberately not reset; they are preloaded through the write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: ready/valid fetch port with fixed response latency
// and a side preload port into the backing array.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 1,
  parameter logic [63:0] BASE_ADDR  = IMEM_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_responder_if.slave       fetch,
  input  logic                  load_ena,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  imem_state_e           state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  err_q;
  logic                  ready_q;
  logic                  valid_q;
  logic                  nop_q;
  logic                  err_out_q;

  logic [61:0]           off_word;
  logic                  err_now;
  logic [DEPTH_LOG2-1:0] idx_now;
  logic                  accept;
  logic                  enter_resp;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_err;
  logic [31:0]           rdata;

  assign off_word = 62'((fetch.inst_addr - BASE_ADDR) >> 2);
  assign err_now  = (fetch.inst_addr[1:0] != 2'b00) || (fetch.inst_addr < BASE_ADDR) ||
                    (|off_word[61:DEPTH_LOG2]);
  assign idx_now  = off_word[DEPTH_LOG2-1:0];
  assign accept   = fetch.inst_ena && ready_q;

  // The array is read on the edge that enters RESP: straight from the request when
  // LATENCY is 1, otherwise from the index latched at accept.
  always_comb begin
    enter_resp = 1'b0;
    rd_idx     = idx_now;
    rd_err     = err_now;
    if (state_q == StWait) begin
      enter_resp = (cnt_q == CntWidth'(1));
      rd_idx     = idx_q;
      rd_err     = err_q;
    end else begin
      enter_resp = accept && (LATENCY == 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      nop_q     <= 1'b1;
      err_out_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StResp: begin
          if (accept) begin
            idx_q <= idx_now;
            err_q <= err_now;
            if (LATENCY == 1) begin
              state_q <= StResp;
              ready_q <= 1'b1;
              valid_q <= 1'b1;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntWidth'(LATENCY - 1);
              ready_q <= 1'b0;
              valid_q <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (cnt_q == CntWidth'(1)) begin
            state_q <= StResp;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
      // inst/inst_err only move when a response is produced, so they hold afterwards.
      if (enter_resp) begin
        nop_q     <= rd_err;
        err_out_q <= rd_err;
      end
    end
  end

  imem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
    .we_i   (load_ena),
    .waddr_i(load_addr),
    .wdata_i(load_data),
    .re_i   (enter_resp),
    .raddr_i(rd_idx),
    .rdata_o(rdata)
  );

  assign fetch.inst_ready = ready_q;
  assign fetch.inst_valid = valid_q;
  assign fetch.inst_err   = err_out_q;
  assign fetch.inst       = nop_q ? INST_NOP : rdata;

endmodule
